// File: rtl/recip_share_arb.sv
// ---------------------------------------------------------------------------
// recip_share_arb
//
// Round-robin arbiter and sequencer that shares one fixed-latency reciprocal
// unit among N requesters. At most one request is granted per cycle. The
// granted operand goes to the shared unit through a register. A tag pipeline
// records the owner of every in-flight operation, so each result returns to
// the requester that issued it as a one-cycle pulse.
//
// Optional feature (compile-time macro RECIP_SHARE_ARB_RANGE_CHK_EN):
//   Granted operands outside the unit's LUT domain (2.0 <= x < 2.5) are
//   tagged as errors. They are not forwarded to the unit. They return with
//   rsp_y = 0 and rsp_err = 1 at the normal latency.
//   Without the macro, every operand is forwarded and rsp_err stays 0.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   issue_en    : when low, no new grants; in-flight operations still drain
//   req_valid   : per-requester request valid (N)
//   req_x       : packed 3QP operands, requester i uses [i*W +: W]
//   req_ready   : one-hot grant, combinational
//   rec_x       : registered operand to the shared reciprocal unit
//   rec_y       : result from the shared unit, valid LAT cycles after rec_x
//   rsp_valid   : one-hot, one-cycle result pulse
//   rsp_y       : registered result, qualified by rsp_valid
//   rsp_err     : range-error flag, qualified by rsp_valid
//   busy        : any operation in flight in the tag pipeline
//   last_grant  : index of the most recent grant
// ---------------------------------------------------------------------------
module recip_share_arb #(
    parameter int N   = 4,
    parameter int P   = 22,
    parameter int LAT = 1,
    parameter int IW  = 2,
    localparam int W  = 3 + P
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_en,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_x,
    output logic [N-1:0]    req_ready,
    output logic [W-1:0]    rec_x,
    input  logic [W-1:0]    rec_y,
    output logic [N-1:0]    rsp_valid,
    output logic [W-1:0]    rsp_y,
    output logic            rsp_err,
    output logic            busy,
    output logic [IW-1:0]   last_grant
);
    // One tag slot per cycle between the grant and the result capture.
    localparam int D = LAT + 1;

    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] last_grant_reg;
    logic [W-1:0]  rec_x_reg;
    logic [N-1:0]  rsp_valid_reg;
    logic [W-1:0]  rsp_y_reg;
    logic          rsp_err_reg;
    logic [D-1:0]  slot_vld_reg;
    logic [D-1:0]  slot_err_reg;
    logic [IW-1:0] slot_idx_reg [D];

    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [W-1:0]  grant_x;
    logic          grant_err;
    logic [W-1:0]  x_arr [N];

    // Unpack the operands so the granted one can be selected by index.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign x_arr[gi]     = req_x[gi*W +: W];
        assign req_ready[gi] = grant_any && (grant_idx == IW'(gi));
    end

    // Search upward from rr_ptr with wrap-around. rr_ptr is always below N,
    // so one conditional subtraction is enough to wrap the candidate index.
    always_comb begin
        logic [IW:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_any && req_valid[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
        if (rst || !issue_en) begin
            grant_any = 1'b0;
        end
    end

    assign grant_x = x_arr[grant_idx];

`ifdef RECIP_SHARE_ARB_RANGE_CHK_EN
    // LUT domain is 2.0 <= x < 2.5: integer bits 3'b010 and first fraction bit 0.
    assign grant_err = !((grant_x[P+2:P] == 3'b010) && !grant_x[P-1]);
`else
    assign grant_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg     <= '0;
            last_grant_reg <= '0;
            rec_x_reg      <= '0;
            rsp_valid_reg  <= '0;
            rsp_y_reg      <= '0;
            rsp_err_reg    <= 1'b0;
            slot_vld_reg   <= '0;
            slot_err_reg   <= '0;
            for (int k = 0; k < D; k++) begin
                slot_idx_reg[k] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr_reg     <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
                last_grant_reg <= grant_idx;
                // An out-of-range operand never reaches the unit.
                if (!grant_err) begin
                    rec_x_reg <= grant_x;
                end
            end

            // The tag pipeline never stalls; slot 0 loads a bubble when idle.
            slot_vld_reg[0] <= grant_any;
            slot_idx_reg[0] <= grant_idx;
            slot_err_reg[0] <= grant_any && grant_err;
            for (int k = 1; k < D; k++) begin
                slot_vld_reg[k] <= slot_vld_reg[k-1];
                slot_idx_reg[k] <= slot_idx_reg[k-1];
                slot_err_reg[k] <= slot_err_reg[k-1];
            end

            // The last slot lines up with the cycle in which rec_y holds the
            // result for that operation.
            if (slot_vld_reg[D-1]) begin
                rsp_valid_reg <= N'(1) << slot_idx_reg[D-1];
                rsp_y_reg     <= slot_err_reg[D-1] ? '0 : rec_y;
                rsp_err_reg   <= slot_err_reg[D-1];
            end else begin
                rsp_valid_reg <= '0;
            end
        end
    end

    assign rec_x      = rec_x_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_y      = rsp_y_reg;
    assign rsp_err    = rsp_err_reg;
    assign busy       = |slot_vld_reg;
    assign last_grant = last_grant_reg;

endmodule

// File: tb/tb_recip_share_arb.sv
// ---------------------------------------------------------------------------
// tb_recip_share_arb
//
// Self-checking bench for recip_share_arb. A behavioural model of the shared
// reciprocal unit drives rec_y. The stimulus side predicts each grant from
// the round-robin rules. It pushes the expected response (owner, 1/x, error
// flag, due cycle) into a scoreboard queue. A separate monitor pops and
// compares that entry whenever the DUT presents rsp_valid.
// Follows the RECIP_SHARE_ARB_RANGE_CHK_EN macro in the same way as the DUT.
// ---------------------------------------------------------------------------
module tb_recip_share_arb;
    localparam int N   = 4;
    localparam int P   = 22;
    localparam int LAT = 1;
    localparam int IW  = 2;
    localparam int W   = 3 + P;

    logic           clk = 1'b0;
    logic           rst;
    logic           issue_en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   rec_x;
    logic [W-1:0]   rec_y;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;
    logic           busy;
    logic [IW-1:0]  last_grant;

    recip_share_arb #(.N(N), .P(P), .LAT(LAT), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .rec_x      (rec_x),
        .rec_y      (rec_y),
        .rsp_valid  (rsp_valid),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] recip(input logic [W-1:0] x);
        longint unsigned num;
        num = 64'd1 << (2 * P);
        if (x == '0) return '0;
        return W'(num / 64'(x));
    endfunction

    function automatic bit mdl_err(input logic [W-1:0] x);
`ifdef RECIP_SHARE_ARB_RANGE_CHK_EN
        return !((longint'(x) >= (longint'(2) << P)) && (longint'(x) < (longint'(5) << (P - 1))));
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- shared-unit model: LAT-cycle pipeline ----------------
    logic [W-1:0] unit_pipe [LAT];
    always @(posedge clk) begin
        unit_pipe[0] <= recip(rec_x);
        for (int k = 1; k < LAT; k++) unit_pipe[k] <= unit_pipe[k-1];
    end
    assign rec_y = unit_pipe[LAT-1];

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- arbitration / sequencing model ----------------
    typedef struct {
        int           idx;
        logic [W-1:0] y;
        logic         err;
        int           due;
    } exp_t;

    exp_t         sb [$];
    int           mdl_rr    = 0;
    int           mdl_last  = 0;
    logic [W-1:0] mdl_rec_x = '0;

    function automatic int mdl_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(mdl_rr + k) % N]) return (mdl_rr + k) % N;
        end
        return -1;
    endfunction

    // Drive one cycle. Outputs are checked at the negedge, and inputs change
    // 1 time unit after the posedge.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] xs,
                               input logic en, input logic r, output int g);
        logic [N-1:0] exp_rdy;
        logic [W-1:0] gx;
        bit           ge;
        bit           exp_busy;
        exp_t         e;
        req_valid = v;
        req_x     = xs;
        issue_en  = en;
        rst       = r;
        @(negedge clk);
        check("rec_x", 64'(rec_x), 64'(mdl_rec_x));
        check("last_grant", 64'(last_grant), 64'(mdl_last));
        exp_busy = 1'b0;
        foreach (sb[k]) if (sb[k].due > cyc) exp_busy = 1'b1;
        check("busy", 64'(busy), 64'(exp_busy));
        g = (r || !en) ? -1 : mdl_pick(v);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g >= 0) begin
            gx    = xs[g*W +: W];
            ge    = mdl_err(gx);
            e.idx = g;
            e.y   = ge ? '0 : recip(gx);
            e.err = ge;
            e.due = cyc + LAT + 2;
            sb.push_back(e);
            mdl_rr   = (g + 1) % N;
            mdl_last = g;
            if (!ge) mdl_rec_x = gx;
            $display("[TB] cycle %0d grant req %0d x=0x%0h err=%0d", cyc, g, gx, ge);
        end
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            mdl_rr    = 0;
            mdl_last  = 0;
            mdl_rec_x = '0;
        end
    endtask

    // ---------------- monitor: pops the scoreboard on every response ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
                check("rsp_y", 64'(rsp_y), 64'(e.y));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_latency", 64'(cyc), 64'(e.due));
                $display("[TB] cycle %0d response req %0d y=0x%0h err=%0d", cyc, e.idx, rsp_y, rsp_err);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("rsp_missing", 64'(rsp_valid), 64'(1) << e.idx);
        end
    end

    // ---------------- requester state ----------------
    bit           pend [N];
    logic [W-1:0] px   [N];

    // sticky = 1 keeps a granted requester asking again with the same operand.
    task automatic step(input logic en, input logic r, input bit sticky);
        logic [N-1:0]   v;
        logic [N*W-1:0] xs;
        int             g;
        for (int i = 0; i < N; i++) begin
            v[i]          = pend[i];
            xs[i*W +: W]  = px[i];
        end
        drive_cycle(v, xs, en, r, g);
        if (g >= 0 && !sticky) pend[g] = 1'b0;
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            px[i]   = '0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        $display("[TB] checking reset outputs (%s)", tag);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rec_x", 64'(rec_x), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_y", 64'(rsp_y), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_last_grant", 64'(last_grant), 64'(0));
    endtask

    function automatic logic [W-1:0] rand_x();
        longint v;
        if ($urandom_range(0, 9) == 0) return W'($urandom);
        v = (longint'(2) << P) + longint'($urandom % (32'd1 << (P - 1)));
        return W'(v);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        issue_en  = 1'b0;
        req_valid = '0;
        req_x     = '0;
        clear_pend();
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst      = 1'b0;
        issue_en = 1'b0;
        check_reset_outputs("power-on");

        // Single request: 2.0 -> 0.5.
        pend[0] = 1'b1;
        px[0]   = W'(32'h080_0000);
        step(1'b1, 1'b0, 1'b0);
        idle(4);

        // All four valid for 8 cycles with distinct operands.
        px[0] = W'(32'h080_0000);
        px[1] = W'(32'h088_0000);
        px[2] = W'(32'h090_0000);
        px[3] = W'(32'h098_0000);
        for (int i = 0; i < N; i++) pend[i] = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1);
        clear_pend();
        idle(4);

        // Move rr_ptr to 2, then requesters 1 and 3 compete: grant 3 (wrap), then 1.
        pend[1] = 1'b1;
        px[1]   = W'(32'h084_0000);
        step(1'b1, 1'b0, 1'b0);
        pend[1] = 1'b1;
        px[1]   = W'(32'h08C_0000);
        pend[3] = 1'b1;
        px[3]   = W'(32'h09C_0000);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(4);

        // Two operations, then issue_en low for 3 cycles while still requesting.
        pend[0] = 1'b1;
        px[0]   = W'(32'h094_0000);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        clear_pend();
        idle(4);

        // Back-to-back operations interrupted by a one-cycle reset.
        pend[2] = 1'b1;
        px[2]   = W'(32'h08A_0000);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        clear_pend();
        rst = 1'b0;
        check_reset_outputs("mid-operation");
        idle(5);

        // Out-of-range operand 3.0.
        pend[0] = 1'b1;
        px[0]   = W'(32'h0C0_0000);
        step(1'b1, 1'b0, 1'b0);
        idle(4);

        // Randomized traffic; requesters hold their operand until granted.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i] = 1'b1;
                    px[i]   = rand_x();
                end
            end
            step(($urandom_range(0, 9) != 0), 1'b0, 1'b0);
        end
        clear_pend();
        idle(8);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recip_share_arb.md
Name: recip_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency reciprocal unit among N requesters.
- The shared unit takes a 3Qp input and returns a 3Qp result; it registers its LUT one cycle, then completes the refinement combinationally.
- The block accepts at most one request per cycle and drives the unit's input from a register.
- It tracks the owner of every in-flight operation in a tag pipeline and routes each result back to its requester with a one-cycle valid pulse.

Parameters:
- N, 4, number of requesters (2..8).
- P, 22, fractional bits of the 3QP operand; word width W = 3+P.
- LAT, 1, cycles from the unit's input to a valid unit output (fixed, >= 1).
- IW, 2, index width, ceil(log2(N)).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_en  in  1  when low, no new grants are made; in-flight operations still drain.
- req_valid  in  N  per-requester request valid.
- req_x  in  N*W  packed operands; requester i uses bits [i*W +: W], format 3QP.
- req_ready  out  N  one-hot grant, combinational from req_valid, rr_ptr and issue_en.
- rec_x  out  W  registered operand to the shared unit.
- rec_y  in  W  shared unit result, 3QP.
- rsp_valid  out  N  one-hot, one-cycle result pulse.
- rsp_y  out  W  registered result; meaningful only while any rsp_valid bit is high.
- rsp_err  out  1  range-error flag, qualified by rsp_valid (see Optional Feature).
- busy  out  1  high while any operation is in flight in the tag pipeline.
- last_grant  out  IW  index of the most recent grant.

Behaviour:
- Reset values: req_ready=0, rec_x=0, rsp_valid=0, rsp_y=0, rsp_err=0, busy=0, last_grant=0, rr_ptr=0, all tag-pipeline slots invalid.
- Arbitration:
  - The search starts at rr_ptr and goes upward with wrap-around; the first i with req_valid[i]=1 is granted.
  - req_ready[i]=1 for that i only. Nothing is granted while issue_en=0 or rst=1.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On a grant to i: rr_ptr <= (i+1) mod N and last_grant <= i. With no grant, rr_ptr holds.
- Requester obligations: hold req_valid and req_x stable until the grant. The block does not check this.
- Issue: on transfer in cycle t, rec_x <= req_x[i] at edge t+1. With no transfer, rec_x holds its value; the unit output is ignored.
- Tag pipeline: depth LAT+1, one slot per cycle.
  - Each slot holds {vld, idx[IW], err}. Slot 0 is loaded on every edge with {transfer, i, err}.
  - Slots shift every cycle and never stall.
- Result capture:
  - When the last slot has vld=1: rsp_y <= rec_y, rsp_valid <= onehot(idx), rsp_err <= err.
  - Otherwise rsp_valid <= 0 and rsp_y holds.
- Latency: transfer in cycle t gives rsp_valid high in cycle t+LAT+2 (3 cycles at the default).
- Throughput: one operation per cycle. Results return strictly in issue order; there is no reordering and no response backpressure, so requesters must sink rsp every cycle.
- busy = OR of all tag-slot vld bits.
- Boundaries:
  - N requesters valid at once: each is served exactly once in N consecutive cycles.
  - rr_ptr wraps from N-1 to 0.
  - issue_en falls mid-stream: in-flight results still return, no new grants.
  - A single continuous requester is granted every cycle.
  - rst asserted mid-operation clears all slots. No rsp_valid appears for operations issued before reset, including at the edge where rst deasserts.

Optional Feature:
- Macro: RECIP_SHARE_ARB_RANGE_CHK_EN.
- With the macro defined:
  - A granted x is in range iff x[P+2:P]==3'b010 and x[P-1]==0, i.e. 2.0 <= x < 2.5, the unit's LUT domain.
  - An out-of-range request is still granted and tagged err=1, and rec_x is not updated.
  - It returns with normal latency: rsp_y=0 and rsp_err=1.
- Without the macro: err is always 0, every operand is forwarded, and rsp_err stays 0.

Test Plan:
- Reset, then req_valid=4'b0001, req_x[0]=0x0800000 (2.0), with a bench model returning 1/x: req_ready[0] in cycle 0, rec_x=0x0800000 at cycle 1, rsp_valid=4'b0001 and rsp_y=0x0200000 (0.5, ±4 LSB) at cycle 3.
- All four valid for 8 cycles, each with distinct x (2.0, 2.125, 2.25, 2.375): grant order 0,1,2,3,0,1,2,3. Responses appear in the same order, and rsp_y for requester 2 is 0x1C71C7 (±4 LSB).
- Requesters 1 and 3 valid, rr_ptr=2: grants go 3, then 1, and rr_ptr wraps to 0 then 2. last_grant reads 3, then 1.
- Issue 2 operations, pull issue_en low for 3 cycles: both results still return; req_ready stays 0 while low, and busy goes 1 to 0 after the drain.
- Issue 3 back-to-back, then assert rst for 1 cycle at cycle 2: no rsp_valid at any later cycle, and all outputs at reset values the cycle after.
- With RECIP_SHARE_ARB_RANGE_CHK_EN, req_x=0x0C00000 (3.0): granted, rec_x unchanged, then rsp_valid, rsp_err=1 and rsp_y=0 at cycle 3. Without the macro, the same stimulus gives rsp_err=0 and rec_x=0x0C00000.
